// File: rtl/imm_pkg.sv
// Shared types and constants for the decode-stage immediate generator.
package imm_pkg;

    // Immediate format select carried from the main decoder.
    typedef enum logic [2:0] {
        IMM_I   = 3'd0,
        IMM_S   = 3'd1,
        IMM_B   = 3'd2,
        IMM_J   = 3'd3,
        IMM_U   = 3'd4,
        IMM_Z   = 3'd5,
        IMM_SH  = 3'd6,
        IMM_BAD = 3'd7
    } immsrc_e;

    // The only datapath widths the core supports.
    localparam int XLEN_RV32 = 32;
    localparam int XLEN_RV64 = 64;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == XLEN_RV32) || (xlen == XLEN_RV64);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction and extension to XLEN.
module imm_decode #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      immsrc,
    output logic [XLEN-1:0] immext,
    output logic            illegal
);
    import imm_pkg::*;

    logic        s;
    logic [31:0] imm32;

    assign s = instr[31];

    // Build every format as a 32-bit value; widening to XLEN is a plain sign extension
    // because the zero-extended formats (Z, SH) always have bit 31 clear.
    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (immsrc_e'(immsrc))
            IMM_I:   imm32 = {{20{s}}, instr[31:20]};
            IMM_S:   imm32 = {{20{s}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{20{s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm32 = {{12{s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_Z:   imm32 = {27'b0, instr[19:15]};
            IMM_SH: begin
                if (XLEN == XLEN_RV64) begin
                    imm32 = {26'b0, instr[25:20]};
                end else begin
                    imm32 = {27'b0, instr[24:20]};
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_wide
            assign immext = {{(XLEN-32){imm32[31]}}, imm32};
        end else begin : g_narrow
            assign immext = imm32[XLEN-1:0];
        end
    endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake and optional 2-entry skid buffer.
module imm_gen_pipe #(
    parameter int XLEN    = 32,
    parameter int SKID_EN = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_immsrc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_immext,
    output logic [31:0]     out_instr,
    output logic            out_illegal
);
    import imm_pkg::*;

    generate
        if (!xlen_legal(XLEN)) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    logic [XLEN-1:0] dec_immext;
    logic            dec_illegal;

    logic            main_valid_reg;
    logic [XLEN-1:0] main_immext_reg;
    logic [31:0]     main_instr_reg;
    logic            main_illegal_reg;
    logic            main_valid_next;
    logic            main_load;
    logic            main_from_skid;

    logic [XLEN-1:0] skid_immext;
    logic [31:0]     skid_instr;
    logic            skid_illegal;

    logic            in_fire;
    logic            out_fire;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .immsrc  (in_immsrc),
        .immext  (dec_immext),
        .illegal (dec_illegal)
    );

    assign in_fire     = in_valid && in_ready;
    assign out_fire    = main_valid_reg && out_ready;
    assign out_valid   = main_valid_reg;
    assign out_immext  = main_immext_reg;
    assign out_instr   = main_instr_reg;
    assign out_illegal = main_illegal_reg;

    // Main output register: loads either the fresh decode or the parked skid entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid_reg   <= 1'b0;
            main_immext_reg  <= '0;
            main_instr_reg   <= '0;
            main_illegal_reg <= 1'b0;
        end else begin
            main_valid_reg <= main_valid_next;
            if (main_load) begin
                if (main_from_skid) begin
                    main_immext_reg  <= skid_immext;
                    main_instr_reg   <= skid_instr;
                    main_illegal_reg <= skid_illegal;
                end else begin
                    main_immext_reg  <= dec_immext;
                    main_instr_reg   <= in_instr;
                    main_illegal_reg <= dec_illegal;
                end
            end
        end
    end

    generate
        if (SKID_EN != 0) begin : g_skid
            logic            skid_valid_reg;
            logic            skid_valid_next;
            logic            skid_load;
            logic            in_ready_reg;
            logic [XLEN-1:0] skid_immext_reg;
            logic [31:0]     skid_instr_reg;
            logic            skid_illegal_reg;

            // Occupancy control: park into skid when main is stalled, drain skid first.
            always_comb begin
                main_valid_next = main_valid_reg;
                main_load       = 1'b0;
                main_from_skid  = 1'b0;
                skid_valid_next = skid_valid_reg;
                skid_load       = 1'b0;
                if (flush) begin
                    main_valid_next = 1'b0;
                    skid_valid_next = 1'b0;
                end else if (skid_valid_reg) begin
                    if (out_fire) begin
                        main_load       = 1'b1;
                        main_from_skid  = 1'b1;
                        skid_valid_next = 1'b0;
                    end
                end else if (main_valid_reg && !out_fire) begin
                    if (in_fire) begin
                        skid_load       = 1'b1;
                        skid_valid_next = 1'b1;
                    end
                end else begin
                    main_valid_next = in_fire;
                    main_load       = in_fire;
                end
            end

            // Skid register and registered in_ready, so no handshake output is combinational.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    skid_valid_reg   <= 1'b0;
                    in_ready_reg     <= 1'b1;
                    skid_immext_reg  <= '0;
                    skid_instr_reg   <= '0;
                    skid_illegal_reg <= 1'b0;
                end else begin
                    skid_valid_reg <= skid_valid_next;
                    in_ready_reg   <= !skid_valid_next;
                    if (skid_load) begin
                        skid_immext_reg  <= dec_immext;
                        skid_instr_reg   <= in_instr;
                        skid_illegal_reg <= dec_illegal;
                    end
                end
            end

            assign in_ready     = in_ready_reg;
            assign skid_immext  = skid_immext_reg;
            assign skid_instr   = skid_instr_reg;
            assign skid_illegal = skid_illegal_reg;
        end else begin : g_single
            assign in_ready     = !main_valid_reg || out_ready;
            assign skid_immext  = '0;
            assign skid_instr   = '0;
            assign skid_illegal = 1'b0;

            // Single stage: a simultaneous push and pop simply replaces the entry.
            always_comb begin
                main_valid_next = main_valid_reg;
                main_load       = 1'b0;
                main_from_skid  = 1'b0;
                if (flush) begin
                    main_valid_next = 1'b0;
                end else if (in_fire) begin
                    main_valid_next = 1'b1;
                    main_load       = 1'b1;
                end else if (out_fire) begin
                    main_valid_next = 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three configurations share one stimulus stream and a queue model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_immsrc;

    logic        rdy_a [3];
    logic        val_a [3];
    logic        ill_a [3];
    logic [31:0] ins_a [3];
    logic [63:0] imm_a [3];
    logic [31:0] imm0;
    logic [63:0] imm1;
    logic [31:0] imm2;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] imm;
        logic        ill;
    } ent_t;

    ent_t q   [3][2];
    int   cnt [3];

    always #5 clk = ~clk;

    // Instance 0: RV32 with skid; 1: RV64 with skid; 2: RV32 single register.
    imm_gen_pipe #(.XLEN(32), .SKID_EN(1)) u_x32 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_a[0]), .in_instr(in_instr), .in_immsrc(in_immsrc),
        .out_valid(val_a[0]), .out_ready(out_ready), .out_immext(imm0),
        .out_instr(ins_a[0]), .out_illegal(ill_a[0])
    );
    imm_gen_pipe #(.XLEN(64), .SKID_EN(1)) u_x64 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_a[1]), .in_instr(in_instr), .in_immsrc(in_immsrc),
        .out_valid(val_a[1]), .out_ready(out_ready), .out_immext(imm1),
        .out_instr(ins_a[1]), .out_illegal(ill_a[1])
    );
    imm_gen_pipe #(.XLEN(32), .SKID_EN(0)) u_s32 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_a[2]), .in_instr(in_instr), .in_immsrc(in_immsrc),
        .out_valid(val_a[2]), .out_ready(out_ready), .out_immext(imm2),
        .out_instr(ins_a[2]), .out_illegal(ill_a[2])
    );

    assign imm_a[0] = {32'b0, imm0};
    assign imm_a[1] = imm1;
    assign imm_a[2] = {32'b0, imm2};

    function automatic int xl_of(input int i);
        return (i == 1) ? 64 : 32;
    endfunction

    function automatic bit sk_of(input int i);
        return (i != 2);
    endfunction

    // Reference immediate built arithmetically: sign weight times a power of two plus fields.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, input int xl);
        longint      v;
        longint      sgn;
        logic [63:0] r;
        v   = longint'($signed(ins));
        sgn = v >>> 31;
        case (src)
            3'd0: r = sgn * 64'd2048 + 64'(ins[30:20]);
            3'd1: r = sgn * 64'd2048 + 64'(ins[30:25]) * 64'd32 + 64'(ins[11:7]);
            3'd2: r = sgn * 64'd4096 + 64'(ins[7]) * 64'd2048 + 64'(ins[30:25]) * 64'd32
                      + 64'(ins[11:8]) * 64'd2;
            3'd3: r = sgn * 64'd1048576 + 64'(ins[19:12]) * 64'd4096 + 64'(ins[20]) * 64'd2048
                      + 64'(ins[30:21]) * 64'd2;
            3'd4: r = sgn * 64'd2147483648 + 64'(ins[30:12]) * 64'd4096;
            3'd5: r = 64'(ins[19:15]);
            3'd6: r = (xl == 64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
            default: r = 64'd0;
        endcase
        if (xl == 32) r = r & 64'hFFFF_FFFF;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare every instance against its model each cycle, then advance the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit   exp_rdy;
            bit   push;
            bit   pop;
            ent_t e;
            if (!reset_n) begin
                cnt[i] = 0;
                chk($sformatf("rst_valid%0d", i), 64'(val_a[i]), 64'd0);
                chk($sformatf("rst_ready%0d", i), 64'(rdy_a[i]), 64'd1);
                chk($sformatf("rst_imm%0d", i), imm_a[i], 64'd0);
                chk($sformatf("rst_ill%0d", i), 64'(ill_a[i]), 64'd0);
            end else begin
                exp_rdy = sk_of(i) ? (cnt[i] < 2) : (cnt[i] == 0 || out_ready);
                chk($sformatf("in_ready%0d", i), 64'(rdy_a[i]), 64'(exp_rdy));
                chk($sformatf("out_valid%0d", i), 64'(val_a[i]), 64'(cnt[i] > 0));
                if (cnt[i] > 0) begin
                    chk($sformatf("out_instr%0d", i), 64'(ins_a[i]), 64'(q[i][0].instr));
                    chk($sformatf("out_immext%0d", i), imm_a[i], q[i][0].imm);
                    chk($sformatf("out_illegal%0d", i), 64'(ill_a[i]), 64'(q[i][0].ill));
                end
                pop  = (cnt[i] > 0) && out_ready;
                push = in_valid && exp_rdy;
                if (flush) begin
                    cnt[i] = 0;
                end else begin
                    if (pop) begin
                        if (i == 0) begin
                            $display("xfer inst0 instr=%h imm=%h ill=%0d t=%0t",
                                     q[i][0].instr, q[i][0].imm, q[i][0].ill, $time);
                        end
                        q[i][0] = q[i][1];
                        cnt[i]--;
                    end
                    if (push) begin
                        e.instr      = in_instr;
                        e.imm        = ref_imm(in_instr, in_immsrc, xl_of(i));
                        e.ill        = (in_immsrc == 3'b111);
                        q[i][cnt[i]] = e;
                        cnt[i]++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated transfer on an empty, free-running pipe; checks the literal result.
    task automatic xfer(input logic [31:0] ins, input logic [2:0] src,
                        input logic [31:0] e32, input logic [63:0] e64, input logic eill);
        chk("idle_valid", 64'(val_a[0]), 64'd0);
        in_valid  = 1'b1;
        in_instr  = ins;
        in_immsrc = src;
        step();
        in_valid = 1'b0;
        chk("lat1_valid", 64'(val_a[0]), 64'd1);
        chk("lit_imm32", imm_a[0], {32'b0, e32});
        chk("lit_imm64", imm_a[1], e64);
        chk("lit_imm32_noskid", imm_a[2], {32'b0, e32});
        chk("lit_illegal", 64'(ill_a[0]), 64'(eill));
        step();
    endtask

    logic [31:0] gotv [3];
    int          got;
    bit          cacc;

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = '0;
        in_immsrc = '0;

        // Pin the model itself against hand-decoded instructions.
        chk("model_I", ref_imm(32'hFFF00093, 3'd0, 32), 64'hFFFF_FFFF);
        chk("model_B", ref_imm(32'hFE000EE3, 3'd2, 32), 64'hFFFF_FFFC);
        chk("model_J", ref_imm(32'hFF9FF06F, 3'd3, 32), 64'hFFFF_FFF8);
        chk("model_U64", ref_imm(32'h800000B7, 3'd4, 64), 64'hFFFF_FFFF_8000_0000);
        chk("model_SH64", ref_imm(32'h03F09093, 3'd6, 64), 64'h3F);
        chk("model_SH32", ref_imm(32'h03F09093, 3'd6, 32), 64'h1F);

        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;

        xfer(32'hFFF00093, 3'd0, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        xfer(32'hFE000EE3, 3'd2, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        xfer(32'hFF9FF06F, 3'd3, 32'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        xfer(32'h800000B7, 3'd4, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
        xfer(32'h03F09093, 3'd6, 32'h0000_001F, 64'h0000_0000_0000_003F, 1'b0);
        xfer(32'hDEADBEEF, 3'd7, 32'h0, 64'h0, 1'b1);
        xfer(32'hFFF00093, 3'd0, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        // Stalled consumer: A, B accepted, C held, then delivered in order.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_immsrc = 3'd0;
        in_instr  = 32'h00A00093;
        step();
        chk("ready_after_A", 64'(rdy_a[0]), 64'd1);
        in_instr = 32'h00B00113;
        step();
        chk("ready_after_B", 64'(rdy_a[0]), 64'd0);
        in_instr = 32'h00C00193;
        step();
        chk("ready_C_held", 64'(rdy_a[0]), 64'd0);
        chk("stall_head", 64'(ins_a[0]), 64'h00A00093);
        out_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 12 && got < 3; k++) begin
            if (val_a[0]) begin
                gotv[got] = ins_a[0];
                got++;
            end
            cacc = in_valid && rdy_a[0];
            step();
            if (cacc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("order_count", 64'(got), 64'd3);
        chk("order_0", 64'(gotv[0]), 64'h00A00093);
        chk("order_1", 64'(gotv[1]), 64'h00B00113);
        chk("order_2", 64'(gotv[2]), 64'h00C00193);
        repeat (4) step();

        // Fill the skid, then flush with an input presented.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_instr = 32'h00100093 + 32'(k);
            step();
        end
        chk("skid_full", 64'(rdy_a[0]), 64'd0);
        flush    = 1'b1;
        in_instr = 32'h0DD00093;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("flush_valid%0d", i), 64'(val_a[i]), 64'd0);
            chk($sformatf("flush_ready%0d", i), 64'(rdy_a[i]), 64'd1);
        end
        step();
        chk("flush_drop", 64'(val_a[0]), 64'd0);

        // Asynchronous reset in the middle of a burst.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_instr  = $urandom;
            in_immsrc = 3'($urandom_range(0, 6));
            step();
        end
        @(negedge clk);
        #1;
        chk("burst_busy", 64'(val_a[0]), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("async_rst%0d", i), 64'(val_a[i]), 64'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Randomised traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            in_valid  = ($urandom % 4) != 0;
            in_instr  = $urandom;
            in_immsrc = 3'($urandom % 8);
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 32) == 0;
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
